sdram_io_window: RTL and testbench
==================================

# sdram_io_window

IO-mapped window into main SDRAM for bulk transfers that bypass the data cache: the CPU loads a 4-word line buffer through IO registers, then commands a single burst store to SDRAM, or commands a burst fetch and reads the line back word by word. It sits on the IO bus alongside serial/keyboard/timer on the CPU side. On the memory side it occupies one SDRAM controller port using the same req/ready/offset burst protocol as the cache and display ports. It raises a one-cycle interrupt when a burst completes.

## Interface
- ADDR_W, 24: SDRAM word-address width presented to the controller port.
- clk  in  1  system clock (clk_sys domain).
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  IO decode select for this block.
- wren  in  1  IO write strobe, qualified by ce.
- ren  in  1  IO read strobe, qualified by ce.
- addr  in  3  register select.
- from_cpu  in  16  IO write data.
- to_cpu  out  16  IO read data, registered.
- irq  out  1  one-cycle pulse on burst completion.
- mem_address  out  ADDR_W  line-aligned word address; bits 1:0 are always 0.
- mem_req  out  1  burst request, held until the 4th ready.
- mem_wren  out  1  1 = store burst, 0 = fetch burst; stable while mem_req is high.
- mem_ready  in  1  per-word strobe from the controller.
- mem_offset  in  2  word index within the line for the current ready strobe.
- to_mem  out  16  store data, = buf[mem_offset] (combinational).
- from_mem  in  16  fetch data, valid when mem_ready is high.

## Operation
- Register map:
  - 0 ADDR_LO: line address bits 15:0.
  - 1 ADDR_HI: bits 7:0 hold address bits 23:16.
  - 2 DATA: access buf[ptr]; ptr increments after each access and wraps 3→0.
  - 3 PTR: bits 1:0.
  - 4 CMD: write 1 = FETCH, 2 = STORE, any other value is ignored. A read returns STATUS: bit0 busy, bit1 done, bit2 err.
  - 5–7: reads return 0, writes are ignored.
- FSM states: IDLE, FETCH, STORE.
  - IDLE→FETCH or IDLE→STORE on a valid CMD write. Done is cleared, mem_req=1, and mem_wren is set per the command.
  - FETCH: each mem_ready writes buf[mem_offset] <= from_mem and increments beat count.
  - STORE: the controller samples to_mem on each mem_ready.
  - After the 4th ready (beat count 3 at ready), return to IDLE. On that edge mem_req=0 and done=1, and irq pulses high for the following cycle.
- While busy:
  - Writes to ADDR_LO, ADDR_HI, DATA, PTR and CMD are ignored and set err.
  - DATA reads return buf[ptr] and do not advance ptr.
- A STATUS read clears done and err on the same edge; the returned value reflects the pre-clear state.
- mem_address = {addr_reg[23:2], 2'b00}. Bits 1:0 written to ADDR_LO are stored but not used for the burst.
- mem_offset order is controller-defined; the block must accept any order and is filled by index, not by arrival order.

## Timing
- Reset values: to_cpu=0, irq=0, mem_req=0, mem_wren=0, address register=0, ptr=0, buf=0, state=IDLE, done=0, err=0. to_mem follows buf, so it resets to 0.
- Reset asserted mid-burst: mem_req drops asynchronously, no irq is generated, and the buffer is cleared.
- Read latency is 1 cycle. to_cpu loads at the edge where ce&ren is sampled, which matches the top-level prev_*_en read muxing. to_cpu holds its value otherwise.
- mem_req rises 1 cycle after the CMD write edge.
- Minimum burst is 4 cycles of back-to-back ready. mem_req falls on the edge that samples the 4th ready.
- ce&wren and ce&ren in the same cycle: the write takes effect, the read returns pre-write data, and ptr advances once.
- A CMD write on the same edge as the final ready of a burst is ignored and sets err (the block is still busy).
- ready while IDLE is ignored.

## Structure
- A package `sdram_io_window_pkg` holds:
  - register address constants (REG_ADDR_LO..REG_CMD);
  - command codes CMD_FETCH=1, CMD_STORE=2;
  - STATUS bit indices;
  - the state enum {IDLE, FETCH, STORE}.
- One sub-module, `line_buffer_4x16`: 4×16 register file with one CPU read/write port and one memory write port (FETCH) indexed by mem_offset, plus a combinational read port for to_mem. The port arbitration is structural: the CPU side is locked out while busy.
- The FSM, beat counter, pointer and status live in the top.

## Test plan
- Store: write ADDR_LO=0x1234, ADDR_HI=0x00, PTR=0, then DATA 0xA000..0xA003, then CMD=2. Required: mem_address=0x001234, mem_wren=1. With ready at offsets 0,1,2,3 → to_mem 0xA000..0xA003; irq pulses once; STATUS=0x2, then 0x0 on the next read.
- Fetch with out-of-order offsets: CMD=1, controller returns offsets 2,0,3,1 with data 0xC2,0xC0,0xC3,0xC1. Then PTR=0 and 4 DATA reads → 0x00C0, 0x00C1, 0x00C2, 0x00C3.
- Busy lockout: during a FETCH, write DATA=0xFFFF and CMD=2. Required: the buffer is unchanged, no second burst starts, STATUS bit2=1, and err clears after that read.
- Pointer wrap: PTR=3, then write DATA twice (0x11, 0x22) → buf[3]=0x11, buf[0]=0x22, PTR reads 1.
- Reset mid-STORE: drop rst_n after 2 readys → mem_req=0 within the same cycle, irq never asserts, and all DATA reads return 0 after reset.

Source files
------------

// File: rtl/sdram_io_window_pkg.sv
// Shared constants and types for the IO-mapped SDRAM line window.
package sdram_io_window_pkg;

    localparam int unsigned LINE_ADDR_W = 24;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned IDX_W       = 2;

    localparam logic [2:0] REG_ADDR_LO = 3'd0;
    localparam logic [2:0] REG_ADDR_HI = 3'd1;
    localparam logic [2:0] REG_DATA    = 3'd2;
    localparam logic [2:0] REG_PTR     = 3'd3;
    localparam logic [2:0] REG_CMD     = 3'd4;

    localparam logic [DATA_W-1:0] CMD_FETCH = 16'd1;
    localparam logic [DATA_W-1:0] CMD_STORE = 16'd2;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STORE = 2'd2
    } state_e;

endpackage

// File: rtl/line_buffer_4x16.sv
// Four-word line register file: CPU read/write port, memory fill port and
// a combinational memory read port for store bursts.
module line_buffer_4x16
    import sdram_io_window_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic [IDX_W-1:0]  cpu_idx,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              mem_we,
    input  logic [IDX_W-1:0]  mem_idx,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata
);

    logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;
    logic [LINE_WORDS-1:0][DATA_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (cpu_we) begin
            line_d[cpu_idx] = cpu_wdata;
        end
        if (mem_we) begin
            line_d[mem_idx] = mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign cpu_rdata = line_q[cpu_idx];
    assign mem_rdata = line_q[mem_idx];

endmodule

// File: rtl/sdram_io_window.sv
// IO register window that moves a 4-word line to/from SDRAM with a single
// burst on one controller port; pulses irq when the burst completes.
module sdram_io_window
    import sdram_io_window_pkg::*;
#(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              wren,
    input  logic              ren,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] from_cpu,
    output logic [DATA_W-1:0] to_cpu,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_req,
    output logic              mem_wren,
    input  logic              mem_ready,
    input  logic [IDX_W-1:0]  mem_offset,
    output logic [DATA_W-1:0] to_mem,
    input  logic [DATA_W-1:0] from_mem
);

    state_e                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       beat_q, beat_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_wren_q, mem_wren_d;
    logic                   irq_q, irq_d;
    logic [DATA_W-1:0]      to_cpu_q, to_cpu_d;

    logic              wr, rd, busy, start, cpu_we, mem_we;
    logic [DATA_W-1:0] cpu_rdata, rd_data, status;

    assign wr     = ce & wren;
    assign rd     = ce & ren;
    assign busy   = (state_q != IDLE);
    assign start  = wr & ~busy & (addr == REG_CMD) &
                    ((from_cpu == CMD_FETCH) | (from_cpu == CMD_STORE));
    assign mem_we = (state_q == FETCH) & mem_ready;

    // CPU port is locked out structurally: its write enable is never raised while busy.
    line_buffer_4x16 u_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_we    (cpu_we),
        .cpu_idx   (ptr_q),
        .cpu_wdata (from_cpu),
        .cpu_rdata (cpu_rdata),
        .mem_we    (mem_we),
        .mem_idx   (mem_offset),
        .mem_wdata (from_mem),
        .mem_rdata (to_mem)
    );

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done_q;
        status[STAT_ERR]  = err_q;
        case (addr)
            REG_ADDR_LO: rd_data = addr_q[15:0];
            REG_ADDR_HI: rd_data = {8'h00, addr_q[23:16]};
            REG_DATA:    rd_data = cpu_rdata;
            REG_PTR:     rd_data = {14'h0000, ptr_q};
            REG_CMD:     rd_data = status;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        done_d     = done_q;
        err_d      = err_q;
        mem_req_d  = mem_req_q;
        mem_wren_d = mem_wren_q;
        irq_d      = 1'b0;
        to_cpu_d   = to_cpu_q;
        cpu_we     = 1'b0;

        // STATUS read clears first so a same-edge error or completion is not lost.
        if (rd) begin
            to_cpu_d = rd_data;
            if (addr == REG_CMD) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
        end

        if (wr && busy && (addr <= REG_CMD)) begin
            err_d = 1'b1;
        end

        if (!busy) begin
            if ((wr || rd) && (addr == REG_DATA)) begin
                ptr_d = ptr_q + 2'd1;
            end
            if (wr) begin
                case (addr)
                    REG_ADDR_LO: addr_d[15:0]  = from_cpu;
                    REG_ADDR_HI: addr_d[23:16] = from_cpu[7:0];
                    REG_DATA:    cpu_we        = 1'b1;
                    REG_PTR:     ptr_d         = from_cpu[1:0];
                    default:     ;
                endcase
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = (from_cpu == CMD_STORE) ? STORE : FETCH;
                    mem_req_d  = 1'b1;
                    mem_wren_d = (from_cpu == CMD_STORE);
                    done_d     = 1'b0;
                    beat_d     = '0;
                end
            end
            FETCH, STORE: begin
                if (mem_ready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                        irq_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ptr_q      <= '0;
            beat_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_wren_q <= 1'b0;
            irq_q      <= 1'b0;
            to_cpu_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            beat_q     <= beat_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_wren_q <= mem_wren_d;
            irq_q      <= irq_d;
            to_cpu_q   <= to_cpu_d;
        end
    end

    assign to_cpu      = to_cpu_q;
    assign irq         = irq_q;
    assign mem_req     = mem_req_q;
    assign mem_wren    = mem_wren_q;
    assign mem_address = ADDR_W'({addr_q[LINE_ADDR_W-1:2], 2'b00});

endmodule

// File: tb/tb_sdram_io_window.sv
// Randomized bench for sdram_io_window against a register-level model of the
// IO window, acting as the SDRAM controller on the memory port.
module tb_sdram_io_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0, wren = 1'b0, ren = 1'b0;
    logic [2:0]  addr = '0;
    logic [15:0] from_cpu = '0;
    logic [15:0] to_cpu;
    logic        irq;
    logic [23:0] mem_address;
    logic        mem_req, mem_wren;
    logic        mem_ready = 1'b0;
    logic [1:0]  mem_offset = '0;
    logic [15:0] to_mem;
    logic [15:0] from_mem = '0;

    sdram_io_window #(.ADDR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .wren(wren), .ren(ren), .addr(addr),
        .from_cpu(from_cpu), .to_cpu(to_cpu), .irq(irq), .mem_address(mem_address),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_ready(mem_ready),
        .mem_offset(mem_offset), .to_mem(to_mem), .from_mem(from_mem)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int irq_count = 0;

    always @(posedge clk) if (irq === 1'b1) irq_count++;

    // Reference model of the register-visible state.
    logic [15:0] m_buf [4];
    logic [1:0]  m_ptr;
    logic [23:0] m_addr;
    bit          m_busy, m_done, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_buf[i] = 16'h0;
        m_ptr = 2'd0; m_addr = 24'h0; m_busy = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [15:0] m_peek(input logic [2:0] a);
        case (a)
            3'd0: return m_addr[15:0];
            3'd1: return {8'h00, m_addr[23:16]};
            3'd2: return m_buf[m_ptr];
            3'd3: return {14'h0, m_ptr};
            3'd4: return {13'h0, m_err, m_done, m_busy};
            default: return 16'h0;
        endcase
    endfunction

    task automatic m_read_fx(input logic [2:0] a);
        if (a == 3'd2 && !m_busy) m_ptr = m_ptr + 2'd1;
        if (a == 3'd4) begin m_done = 0; m_err = 0; end
    endtask

    // CMD values that start a burst are handled by start_cmd, not here.
    task automatic m_write(input logic [2:0] a, input logic [15:0] d);
        if (a <= 3'd4 && m_busy) begin
            m_err = 1;
        end else begin
            case (a)
                3'd0: m_addr[15:0] = d;
                3'd1: m_addr[23:16] = d[7:0];
                3'd2: begin m_buf[m_ptr] = d; m_ptr = m_ptr + 2'd1; end
                3'd3: m_ptr = d[1:0];
                default: ;
            endcase
        end
    endtask

    task automatic io(input bit w, input bit r, input logic [2:0] a, input logic [15:0] d,
                      output logic [15:0] q);
        ce = 1'b1; wren = w; ren = r; addr = a; from_cpu = d;
        @(posedge clk); #1;
        ce = 1'b0; wren = 1'b0; ren = 1'b0;
        q = to_cpu;
    endtask

    task automatic cpu_op(input bit w, input bit r, input logic [2:0] a, input logic [15:0] d,
                          output logic [15:0] q);
        logic [15:0] exp;
        exp = m_peek(a);
        if (w && r && a == 3'd2 && !m_busy) begin
            m_buf[m_ptr] = d;
            m_ptr = m_ptr + 2'd1;
        end else begin
            if (r) m_read_fx(a);
            if (w) m_write(a, d);
        end
        io(w, r, a, d, q);
        if (r) chk($sformatf("read reg%0d", a), {16'h0, q}, {16'h0, exp});
    endtask

    task automatic start_cmd(input logic [15:0] cmd);
        logic [15:0] q;
        io(1'b1, 1'b0, 3'd4, cmd, q);
        m_busy = 1; m_done = 0;
        chk("req after cmd", {31'h0, mem_req}, 32'h1);
        chk("wren after cmd", {31'h0, mem_wren}, {31'h0, (cmd == 16'd2)});
        chk("mem_address", {8'h0, mem_address}, {8'h0, m_addr[23:2], 2'b00});
    endtask

    task automatic run_beats(input bit is_store, input logic [3:0][1:0] offs,
                             input logic [3:0][15:0] data, input int max_gap);
        int irq0;
        irq0 = irq_count;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
                chk("req held in gap", {31'h0, mem_req}, 32'h1);
            end
            mem_ready = 1'b1; mem_offset = offs[i]; from_mem = data[i];
            #1;
            if (is_store) chk($sformatf("to_mem beat%0d", i), {16'h0, to_mem}, {16'h0, m_buf[offs[i]]});
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (!is_store) m_buf[offs[i]] = data[i];
        end
        chk("req drop at 4th ready", {31'h0, mem_req}, 32'h0);
        chk("irq pulse", {31'h0, irq}, 32'h1);
        m_busy = 0; m_done = 1;
        @(posedge clk); #1;
        chk("irq one cycle", {31'h0, irq}, 32'h0);
        chk("irq count", irq_count - irq0, 1);
    endtask

    function automatic logic [3:0][1:0] rand_perm();
        logic [3:0][1:0] p;
        logic [1:0] t;
        int j;
        for (int i = 0; i < 4; i++) p[i] = 2'(i);
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        return p;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic [3:0][1:0] offs;
        logic [3:0][15:0] data;
        int irq0, op;
        bit w, r;
        logic [2:0] a;
        logic [15:0] d;

        m_reset();
        #3;
        chk("rst to_cpu", {16'h0, to_cpu}, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        chk("rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst mem_wren", {31'h0, mem_wren}, 32'h0);
        chk("rst mem_address", {8'h0, mem_address}, 32'h0);
        chk("rst to_mem", {16'h0, to_mem}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_op(0, 1, 3'd4, 16'h0, q);
        cpu_op(0, 1, 3'd3, 16'h0, q);

        // Store burst of a CPU-loaded line
        cpu_op(1, 0, 3'd0, 16'h1234, q);
        cpu_op(1, 0, 3'd1, 16'h0000, q);
        cpu_op(1, 0, 3'd3, 16'h0000, q);
        for (int i = 0; i < 4; i++) cpu_op(1, 0, 3'd2, 16'hA000 + 16'(i), q);
        start_cmd(16'd2);
        chk("store address", {8'h0, mem_address}, 32'h001234);
        for (int i = 0; i < 4; i++) begin offs[i] = 2'(i); data[i] = 16'h0; end
        run_beats(1'b1, offs, data, 0);
        cpu_op(0, 1, 3'd4, 16'h0, q);
        chk("status after store", {16'h0, q}, 32'h2);
        cpu_op(0, 1, 3'd4, 16'h0, q);
        chk("status cleared", {16'h0, q}, 32'h0);

        // Fetch with out-of-order offsets
        start_cmd(16'd1);
        offs[0] = 2'd2; offs[1] = 2'd0; offs[2] = 2'd3; offs[3] = 2'd1;
        data[0] = 16'h00C2; data[1] = 16'h00C0; data[2] = 16'h00C3; data[3] = 16'h00C1;
        run_beats(1'b0, offs, data, 0);
        cpu_op(1, 0, 3'd3, 16'h0, q);
        for (int i = 0; i < 4; i++) begin
            cpu_op(0, 1, 3'd2, 16'h0, q);
            chk("fetch order", {16'h0, q}, 32'h00C0 + i);
        end
        cpu_op(0, 1, 3'd4, 16'h0, q);

        // Busy lockout during a fetch
        cpu_op(1, 0, 3'd3, 16'h1, q);
        start_cmd(16'd1);
        cpu_op(0, 1, 3'd2, 16'h0, q);
        cpu_op(1, 0, 3'd2, 16'hFFFF, q);
        cpu_op(0, 1, 3'd2, 16'h0, q);
        chk("busy data unchanged", {16'h0, q}, 32'h00C1);
        cpu_op(1, 0, 3'd4, 16'd2, q);
        chk("no restart wren", {31'h0, mem_wren}, 32'h0);
        cpu_op(0, 1, 3'd3, 16'h0, q);
        cpu_op(0, 1, 3'd4, 16'h0, q);
        chk("busy status", {16'h0, q}, 32'h5);
        for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
        run_beats(1'b0, rand_perm(), data, 1);
        repeat (3) @(posedge clk);
        #1 chk("no second burst", {31'h0, mem_req}, 32'h0);
        cpu_op(0, 1, 3'd4, 16'h0, q);
        chk("err cleared", {16'h0, q}, 32'h2);

        // Pointer wrap
        cpu_op(1, 0, 3'd3, 16'h3, q);
        cpu_op(1, 0, 3'd2, 16'h0011, q);
        cpu_op(1, 0, 3'd2, 16'h0022, q);
        cpu_op(0, 1, 3'd3, 16'h0, q);
        chk("ptr wrap", {16'h0, q}, 32'h1);
        cpu_op(1, 0, 3'd3, 16'h3, q);
        cpu_op(0, 1, 3'd2, 16'h0, q);
        chk("buf3", {16'h0, q}, 32'h0011);
        cpu_op(0, 1, 3'd2, 16'h0, q);
        chk("buf0", {16'h0, q}, 32'h0022);

        // Randomized mix of register traffic, bursts and stray readys
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(9, 0);
            if (op <= 5) begin
                a = 3'($urandom_range(7, 0));
                w = 1'($urandom); r = 1'($urandom);
                if (!w && !r) r = 1;
                d = 16'($urandom);
                if (a == 3'd4 && (d == 16'd1 || d == 16'd2)) d = 16'h0;
                cpu_op(w, r, a, d, q);
            end else if (op <= 8) begin
                d = 16'($urandom_range(2, 1));
                start_cmd(d);
                if ($urandom_range(1, 0) == 1) begin
                    a = 3'($urandom_range(7, 0));
                    cpu_op(1'($urandom), 1'b1, a, 16'($urandom), q);
                end
                for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
                run_beats(d == 16'd2, rand_perm(), data, 2);
            end else begin
                mem_ready = 1'b1; mem_offset = 2'($urandom); from_mem = 16'($urandom);
                @(posedge clk); #1;
                mem_ready = 1'b0;
                chk("stray ready irq", {31'h0, irq}, 32'h0);
                chk("stray ready req", {31'h0, mem_req}, 32'h0);
            end
        end
        cpu_op(1, 0, 3'd3, 16'h0, q);
        for (int i = 0; i < 4; i++) cpu_op(0, 1, 3'd2, 16'h0, q);

        // Reset in the middle of a store burst
        for (int i = 0; i < 4; i++) cpu_op(1, 0, 3'd2, 16'($urandom) | 16'h1, q);
        start_cmd(16'd2);
        irq0 = irq_count;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1; mem_offset = 2'(i);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; mem_offset = 2'd2;
        #2 rst_n = 1'b0;
        #1 chk("async req drop", {31'h0, mem_req}, 32'h0);
        mem_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no irq after reset", irq_count - irq0, 0);
        for (int i = 0; i < 4; i++) begin
            cpu_op(0, 1, 3'd2, 16'h0, q);
            chk("buf cleared", {16'h0, q}, 32'h0);
        end
        cpu_op(0, 1, 3'd4, 16'h0, q);
        chk("status after reset", {16'h0, q}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
